i2c_cmd_arbiter: RTL and testbench
==================================

# i2c_cmd_arbiter

Shares the single codec I2C master between two command sources: the power-up codec initialisation sequencer (port 0) and the runtime control path (port 1; volume, mute, input select). Each accepted 16-bit command word ({7-bit register address, 9-bit data}) is issued to the master with a level GO / pulse DONE handshake. NACKs are retried up to a bounded count and hung transfers time out. Completion and error are reported back to the originating port only.

## Interface
- MAX_RETRY, default 3: re-issues after a NACK before error (0 = no retry).
- GAP_CYC, default 16: clk cycles with m_go low between a NACK and its retry.
- TIMEOUT_CYC, default 65535: clk cycles in WAIT before abort; counter 16 bits wide.
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  2  per-port command valid; held until req_ready
- req_data  in  2x16  per-port command word; bits [15:0] port 0, [31:16] port 1
- req_ready  out  2  one-cycle accept pulse to the granted port
- rsp_done  out  2  one-cycle completion pulse to the granted port
- rsp_err  out  1  failure flag, valid with rsp_done (NACK exhausted or timeout)
- m_go  out  1  I2C master start, level
- m_data  out  16  word to master, stable while m_go high
- m_done  in  1  master completion pulse, synchronous to clk
- m_nack  in  1  slave did not acknowledge, sampled with m_done
- busy  out  1  high in every state except IDLE
- timeout_flag  out  1  sticky; set on any timeout, cleared only by reset

## Operation
- States: IDLE, ISSUE, WAIT, GAP, RESP.
- IDLE:
  - If any req_valid is high, grant via round-robin. The port granted last has the lower priority. After reset, port 0 has priority.
  - req_ready pulses for the winner in the same cycle.
  - req_data latches into m_data. retry_cnt clears to 0. Go to ISSUE.
- ISSUE: m_go rises (registered), wait counter clears. Go to WAIT.
- WAIT: m_go held high. Wait counter increments each cycle.
  - m_done with m_nack=0: go to RESP, err=0.
  - m_done with m_nack=1 and retry_cnt<MAX_RETRY: retry_cnt++, go to GAP.
  - m_done with m_nack=1 and retry_cnt==MAX_RETRY: go to RESP, err=1.
  - Wait counter == TIMEOUT_CYC-1 with no m_done: go to RESP, err=1, set timeout_flag.
  - m_done in the same cycle as the timeout edge: m_done wins.
- GAP: m_go low for GAP_CYC cycles, m_data unchanged, then go to ISSUE.
- RESP: rsp_done pulses on the granted port with rsp_err. m_go low. Go to IDLE.
- A request arriving in any state other than IDLE waits; req_ready stays low.
- m_done outside WAIT is ignored.
- m_go is low for at least 2 cycles between any two transfers (RESP+IDLE, or GAP).

## Timing
- Reset values: m_go=0, m_data=0, req_ready=0, rsp_done=0, rsp_err=0, busy=0, timeout_flag=0, state IDLE, RR pointer favours port 0.
- Accept latency: req_ready pulses in the first IDLE cycle where req_valid is high (combinational from valid and state).
- m_go rises 1 cycle after req_ready.
- Successful transfer: rsp_done asserts 1 cycle after m_done. The next accept is possible 1 cycle after that.
- Per retry: GAP_CYC+1 cycles from the NACK m_done to m_go high again.
- Simultaneous valid on both ports: one grant per transfer, so the two ports strictly alternate.
- Reset mid-transfer: all outputs return to reset values immediately. m_go drops asynchronously. The aborted command gets no rsp_done.

## Structure
- Package codec_ctrl_pkg holds:
  - state enum
  - I2C_WORD_W=16
  - REG_ADDR_W=7
  - REG_DATA_W=9
  - N_REQ=2
- Sub-module rr_arbiter2: 2-way round-robin grant with pointer update on accept; about 40 lines.
- The top level holds the FSM, retry counter, wait counter and GAP counter.

## Test plan
- **Single command:** port 0 sends 0x0C6A; master returns m_done, nack=0, 10 cycles after m_go. Required: req_ready at t0, m_go at t0+1, m_data=0x0C6A, rsp_done[0]=1 with rsp_err=0 one cycle after m_done.
- **Contention:** both ports valid continuously with 3 words each. Grants must go 0,1,0,1,0,1. No rsp_done on the wrong port.
- **NACK retry:** MAX_RETRY=3. Two NACKs, then an ACK. Required: 3 m_go pulses, each gap ≥ GAP_CYC low cycles, one rsp_done with err=0.
- **NACK exhaustion:** NACK every time. Required: 4 m_go pulses, then rsp_done with err=1, and the arbiter returns to IDLE.
- **Timeout:** TIMEOUT_CYC=100, no m_done. Required: m_go drops, rsp_done with err=1 at cycle 100 of WAIT, timeout_flag=1 and stays set through later transfers.
- **Reset mid-WAIT:** rst_n low during WAIT. Required: m_go=0 and busy=0 immediately. After release, port 0 wins a tie.

Source files
------------

// File: rtl/codec_ctrl_pkg.sv
// Shared types and widths for the codec control I2C command path.
package codec_ctrl_pkg;

    localparam int I2C_WORD_W = 16;
    localparam int REG_ADDR_W = 7;
    localparam int REG_DATA_W = 9;
    localparam int N_REQ      = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_GAP,
        ST_RESP
    } arb_state_e;

endpackage

// File: rtl/i2c_cmd_arbiter_rr.sv
// Two-way round-robin grant; the port granted last drops to low priority.
module rr_arbiter2
    import codec_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             accept,
    output logic [N_REQ-1:0] grant
);

    // 1 = port 1 was granted last; reset value hands the first tie to port 0
    logic last_grant;

    // Resolve the grant from the live requests and the last winner
    always_comb begin
        grant = '0;
        if (req[0] && req[1]) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end else begin
            grant = req;
        end
    end

    // Move the priority pointer only when the grant is actually taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (accept && (grant != '0)) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// Shares the codec I2C master between the init sequencer (port 0) and the
// runtime control path (port 1), with NACK retry and transfer timeout.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no transfer; grant a pending request round-robin
// ST_ISSUE | m_go rises, wait counter cleared
// ST_WAIT  | m_go held, waiting for m_done or timeout
// ST_GAP   | m_go low between a NACK and its retry
// ST_RESP  | one-cycle rsp_done/rsp_err to the originating port
module i2c_cmd_arbiter
    import codec_ctrl_pkg::*;
#(
    parameter int MAX_RETRY   = 3,
    parameter int GAP_CYC     = 16,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*I2C_WORD_W-1:0] req_data,
    output logic [N_REQ-1:0]            req_ready,
    output logic [N_REQ-1:0]            rsp_done,
    output logic                        rsp_err,
    output logic                        m_go,
    output logic [I2C_WORD_W-1:0]       m_data,
    input  logic                        m_done,
    input  logic                        m_nack,
    output logic                        busy,
    output logic                        timeout_flag
);

    localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRY);
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYC - 1);
    localparam logic [15:0] GAP_LAST  = 16'(GAP_CYC - 1);

    arb_state_e       state;
    arb_state_e       state_nxt;
    logic [N_REQ-1:0] grant;
    logic             accept;
    logic             port_q;
    logic             err_q;
    logic             err_nxt;
    logic             retry_inc;
    logic             set_tmo;
    logic [7:0]       retry_cnt;
    logic [15:0]      wait_cnt;
    logic [15:0]      gap_cnt;

    assign accept = (state == ST_IDLE) && (req_valid != '0);

    rr_arbiter2 u_rr (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req_valid),
        .accept (accept),
        .grant  (grant)
    );

    // Handshake outputs decoded from the current state
    always_comb begin
        req_ready = (state == ST_IDLE) ? grant : '0;
        rsp_done  = '0;
        if (state == ST_RESP) begin
            rsp_done[port_q] = 1'b1;
        end
        rsp_err = (state == ST_RESP) && err_q;
        busy    = (state != ST_IDLE);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; m_done beats the timeout when both land together
    always_comb begin
        state_nxt = state;
        err_nxt   = err_q;
        retry_inc = 1'b0;
        set_tmo   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid != '0) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (m_done) begin
                    if (!m_nack) begin
                        state_nxt = ST_RESP;
                        err_nxt   = 1'b0;
                    end else if (retry_cnt < RETRY_MAX) begin
                        state_nxt = ST_GAP;
                        retry_inc = 1'b1;
                    end else begin
                        state_nxt = ST_RESP;
                        err_nxt   = 1'b1;
                    end
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt = ST_RESP;
                    err_nxt   = 1'b1;
                    set_tmo   = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt == '0) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath: registered m_go, command latch, retry/wait/gap counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_go         <= 1'b0;
            m_data       <= '0;
            port_q       <= 1'b0;
            err_q        <= 1'b0;
            retry_cnt    <= '0;
            wait_cnt     <= '0;
            gap_cnt      <= '0;
            timeout_flag <= 1'b0;
        end else begin
            m_go  <= (state_nxt == ST_ISSUE) || (state_nxt == ST_WAIT);
            err_q <= err_nxt;

            if (accept) begin
                m_data <= grant[1] ? req_data[I2C_WORD_W +: I2C_WORD_W]
                                   : req_data[0 +: I2C_WORD_W];
                port_q <= grant[1];
            end

            if (accept) begin
                retry_cnt <= '0;
            end else if (retry_inc) begin
                retry_cnt <= retry_cnt + 8'd1;
            end

            if (state == ST_ISSUE) begin
                wait_cnt <= '0;
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt + 16'd1;
            end

            // Down-count of the low time; leaves GAP on terminal count zero
            if ((state_nxt == ST_GAP) && (state != ST_GAP)) begin
                gap_cnt <= GAP_LAST;
            end else if ((state == ST_GAP) && (gap_cnt != '0)) begin
                gap_cnt <= gap_cnt - 16'd1;
            end

            if (set_tmo) begin
                timeout_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Directed bench for i2c_cmd_arbiter: a table of single transactions plus
// hand-written contention and reset-mid-transfer sequences.
module tb_i2c_cmd_arbiter;

    localparam int MAX_RETRY   = 3;
    localparam int GAP_CYC     = 16;
    localparam int TIMEOUT_CYC = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_done;
    logic        rsp_err;
    logic        m_go;
    logic [15:0] m_data;
    logic        m_done = 1'b0;
    logic        m_nack = 1'b0;
    logic        busy;
    logic        timeout_flag;

    i2c_cmd_arbiter #(
        .MAX_RETRY   (MAX_RETRY),
        .GAP_CYC     (GAP_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .rsp_done     (rsp_done),
        .rsp_err      (rsp_err),
        .m_go         (m_go),
        .m_data       (m_data),
        .m_done       (m_done),
        .m_nack       (m_nack),
        .busy         (busy),
        .timeout_flag (timeout_flag)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc++;

    function automatic void chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endfunction

    // ---------------- requesters: one word queue per port ----------------
    logic [15:0] q0[$];
    logic [15:0] q1[$];
    logic [1:0]  acc = '0;

    always @(negedge clk) acc = req_ready & req_valid;

    always @(posedge clk) begin
        #1;
        if (acc[0] && q0.size() > 0) void'(q0.pop_front());
        if (acc[1] && q1.size() > 0) void'(q1.pop_front());
        req_valid[0]     = (q0.size() > 0);
        req_data[15:0]   = (q0.size() > 0) ? q0[0] : 16'h0;
        req_valid[1]     = (q1.size() > 0);
        req_data[31:16]  = (q1.size() > 0) ? q1[0] : 16'h0;
    end

    // ---------------- I2C master model ----------------
    int mst_delay = 0;   // cycles from m_go rise to m_done; 0 = never answers
    int mst_nacks = 0;   // NACK this many attempts, then ACK
    int nack_seen = 0;
    int go_cnt    = 0;

    always @(posedge clk) begin
        #1;
        m_done = 1'b0;
        m_nack = 1'b0;
        if (!m_go) begin
            go_cnt = 0;
        end else begin
            go_cnt++;
            if (mst_delay != 0 && go_cnt == mst_delay) begin
                m_done = 1'b1;
                if (nack_seen < mst_nacks) begin
                    m_nack = 1'b1;
                    nack_seen++;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    bit         grant_log[$];
    logic [2:0] rsp_log[$];   // {rsp_done[1:0], rsp_err}
    bit         last_port = 1'b0;
    bit         go_prev = 1'b0;
    bit         nack_pending = 1'b0;
    int         lowrun = 0;
    int         pulses = 0;
    int         t_ready = 0, t_go = 0, t_mdone = 0, t_rsp = 0;
    logic [15:0] go_word = '0;
    logic [15:0] go_data = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (req_ready != 2'b00) begin
                chk("req_ready_onehot", int'($countones(req_ready)), 1);
                grant_log.push_back(req_ready[1]);
                last_port = req_ready[1];
                t_ready   = cyc;
            end
            if (m_done) begin
                t_mdone      = cyc;
                nack_pending = m_nack;
            end
            if (m_go && !go_prev) begin
                if (pulses == 0) begin
                    t_go    = cyc;
                    go_word = m_data;
                end else begin
                    chk("min_go_low", int'(lowrun >= 2), 1);
                    if (nack_pending) begin
                        chk("gap_low_cycles", lowrun, GAP_CYC);
                        chk("retry_latency", cyc - t_mdone, GAP_CYC + 1);
                    end
                end
                pulses++;
                go_data = m_data;
            end else if (m_go && go_prev) begin
                chk("m_data_stable", int'(m_data), int'(go_data));
            end
            lowrun  = m_go ? 0 : lowrun + 1;
            go_prev = m_go;
            if (rsp_done != 2'b00) begin
                chk("rsp_port", int'(rsp_done), last_port ? 2 : 1);
                rsp_log.push_back({rsp_done, rsp_err});
                t_rsp        = cyc;
                nack_pending = 1'b0;
            end
        end else begin
            go_prev = m_go;
        end
    end

    task automatic clear_logs();
        grant_log.delete();
        rsp_log.delete();
        pulses    = 0;
        nack_seen = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic wait_rsp(input int n, input int budget, output bit ok);
        int k = 0;
        while (rsp_log.size() < n && k < budget) begin
            @(negedge clk);
            #2;
            k++;
        end
        ok = (rsp_log.size() >= n);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL wait_rsp: got %0d responses, expected %0d within %0d cycles",
                     rsp_log.size(), n, budget);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int          port;
        logic [15:0] word;
        int          delay;
        int          nacks;
        bit          exp_err;
        int          exp_pulses;
        int          exp_lat;     // m_go rise to rsp_done, 0 = unchecked
        bit          exp_tflag;
    } vec_t;

    vec_t vecs[8];

    initial begin
        bit ok;
        int k;

        vecs[0] = '{0, 16'h0C6A,  10,  0, 1'b0, 1,  10, 1'b0};
        vecs[1] = '{1, 16'hA5F1,   3,  0, 1'b0, 1,   3, 1'b0};
        vecs[2] = '{0, 16'h1234,   5,  2, 1'b0, 3,   0, 1'b0};
        vecs[3] = '{1, 16'h7E01,   4, 99, 1'b1, 4,   0, 1'b0};
        vecs[4] = '{0, 16'h2BCD, 101,  0, 1'b0, 1, 101, 1'b0};
        vecs[5] = '{1, 16'h0001, 102,  0, 1'b1, 1, 101, 1'b1};
        vecs[6] = '{0, 16'h3300,   1,  0, 1'b1, 1, 101, 1'b1};
        vecs[7] = '{1, 16'h5A5A,   2,  0, 1'b0, 1,   2, 1'b1};

        // Reset values
        repeat (3) @(negedge clk);
        #2;
        chk("rst_m_go", int'(m_go), 0);
        chk("rst_m_data", int'(m_data), 0);
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_rsp_done", int'(rsp_done), 0);
        chk("rst_rsp_err", int'(rsp_err), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_timeout_flag", int'(timeout_flag), 0);
        rst_n = 1'b1;
        @(negedge clk);
        #2;

        // Table of single transactions
        for (int i = 0; i < 8; i++) begin
            clear_logs();
            mst_delay = vecs[i].delay;
            mst_nacks = vecs[i].nacks;
            if (vecs[i].port == 0) q0.push_back(vecs[i].word);
            else                   q1.push_back(vecs[i].word);
            wait_rsp(1, 1000, ok);
            if (ok) begin
                chk($sformatf("v%0d_grants", i), grant_log.size(), 1);
                chk($sformatf("v%0d_grant_port", i), int'(grant_log[0]), vecs[i].port);
                chk($sformatf("v%0d_m_data", i), int'(go_word), int'(vecs[i].word));
                chk($sformatf("v%0d_ready_to_go", i), t_go - t_ready, 1);
                chk($sformatf("v%0d_rsp_port", i), int'(rsp_log[0][2:1]), vecs[i].port == 0 ? 1 : 2);
                chk($sformatf("v%0d_rsp_err", i), int'(rsp_log[0][0]), int'(vecs[i].exp_err));
                chk($sformatf("v%0d_go_pulses", i), pulses, vecs[i].exp_pulses);
                if (vecs[i].exp_lat != 0)
                    chk($sformatf("v%0d_go_to_rsp", i), t_rsp - t_go, vecs[i].exp_lat);
                if (!vecs[i].exp_err)
                    chk($sformatf("v%0d_done_to_rsp", i), t_rsp - t_mdone, 1);
                @(negedge clk);
                #2;
                chk($sformatf("v%0d_idle_busy", i), int'(busy), 0);
                chk($sformatf("v%0d_m_go_low", i), int'(m_go), 0);
                chk($sformatf("v%0d_timeout_flag", i), int'(timeout_flag), int'(vecs[i].exp_tflag));
            end
        end

        // Contention: both ports hold valid with 3 words each
        do_reset();
        @(negedge clk);
        #2;
        chk("cont_tflag_cleared", int'(timeout_flag), 0);
        clear_logs();
        mst_delay = 3;
        mst_nacks = 0;
        for (int i = 0; i < 3; i++) begin
            q0.push_back(16'h0100 + 16'(i));
            q1.push_back(16'h8200 + 16'(i));
        end
        wait_rsp(6, 500, ok);
        if (ok) begin
            @(negedge clk);
            #2;
            chk("cont_grant_count", grant_log.size(), 6);
            chk("cont_rsp_count", rsp_log.size(), 6);
            for (int i = 0; i < 6 && i < grant_log.size(); i++) begin
                chk($sformatf("cont_grant_%0d", i), int'(grant_log[i]), i % 2);
                chk($sformatf("cont_rsp_%0d", i), int'(rsp_log[i]), (i % 2 == 0) ? 3'b010 : 3'b100);
            end
        end

        // Reset in the middle of WAIT on a port-0 transfer
        clear_logs();
        mst_delay = 0;
        q0.push_back(16'h4C21);
        k = 0;
        while (!(busy && m_go) && k < 50) begin
            @(negedge clk);
            #2;
            k++;
        end
        chk("mid_reached_wait", int'(busy && m_go), 1);
        repeat (3) @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_m_go_async", int'(m_go), 0);
        chk("mid_busy_async", int'(busy), 0);
        chk("mid_m_data_async", int'(m_data), 0);
        chk("mid_rsp_done_async", int'(rsp_done), 0);
        q0.delete();
        q1.delete();
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        chk("mid_no_rsp", rsp_log.size(), 0);

        clear_logs();
        mst_delay = 3;
        q0.push_back(16'h1111);
        q1.push_back(16'h2222);
        wait_rsp(2, 200, ok);
        if (ok) begin
            chk("post_rst_first_grant", int'(grant_log[0]), 0);
            chk("post_rst_second_grant", int'(grant_log[1]), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_vec);
        $fatal(1, "watchdog");
    end

endmodule
